segre_mem_arbiter: RTL and testbench
====================================

Name: segre_mem_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (IF, read-only word accesses) and the data memop path (loads and stores, driven by the decoded memop_rd/memop_wr/memop_type/memop_sign_ext controls).
- Sits between the IF/MEM pipeline stages and the memory interface.
- Allows one outstanding transaction. Data has priority; a starvation counter guarantees fetch forward progress.

Parameters:
ADDR_SIZE, 32, memory address width
WORD_SIZE, 32, data width (from segre_pkg)
STARVE_LIMIT, 4, consecutive IDLE cycles a pending fetch may lose arbitration before it is forced to win; 0 disables the override

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset, asynchronous, active-low
if_req_i  in  1  fetch request, held until if_gnt_o
if_addr_i  in  ADDR_SIZE  fetch address
if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
if_rvalid_o  out  1  fetch data valid (1-cycle pulse)
if_rdata_o  out  WORD_SIZE  fetched instruction
dm_rd_i  in  1  load request, held until dm_gnt_o
dm_wr_i  in  1  store request, held until dm_gnt_o
dm_addr_i  in  ADDR_SIZE  data address
dm_wdata_i  in  WORD_SIZE  store data
dm_type_i  in  memop_data_type_e  BYTE/HALF/WORD
dm_gnt_o  out  1  data request accepted (pulse)
dm_rvalid_o  out  1  load data valid, or store complete (pulse)
dm_rdata_o  out  WORD_SIZE  load data, unmodified
mem_req_o  out  1  memory request
mem_we_o  out  1  write enable
mem_addr_o  out  ADDR_SIZE  address
mem_wdata_o  out  WORD_SIZE  write data
mem_type_o  out  memop_data_type_e  access size
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  memory response / write acknowledge
mem_rdata_i  in  WORD_SIZE  read data

Behaviour:
- Reset: every output is 0, except mem_type_o = WORD. State = IDLE, starve_q = 0, owner_q = IF.
- FSM states:
  - IDLE: arbitrate and accept.
  - REQ: mem_req_o = 1 with registered fields.
  - WAIT: awaiting mem_rvalid_i.
- IDLE arbitration (combinational grant):
  - Data wins if (dm_rd_i | dm_wr_i) and not (if_req_i and STARVE_LIMIT != 0 and starve_q == STARVE_LIMIT). Otherwise IF wins if if_req_i.
  - The winner's gnt_o pulses in this cycle. Address, wdata, type, we and owner are latched. Next state = REQ.
  - IF fields: we = 0, type = WORD.
- starve_q:
  - Increments (saturating at STARVE_LIMIT) in any IDLE cycle where if_req_i = 1 and data wins.
  - Clears when IF is granted.
  - Holds in REQ and WAIT.
- REQ:
  - mem_* outputs are driven from registers; they are stable while mem_req_o = 1.
  - On mem_gnt_i, mem_req_o drops next cycle. Go to WAIT, or to IDLE if mem_rvalid_i is also high in the same cycle.
- WAIT: on mem_rvalid_i, go to IDLE.
- Response path:
  - mem_rvalid_i in REQ (with gnt) or WAIT registers rdata into the owner's rdata_o. The owner's rvalid_o pulses the next cycle, which coincides with the first IDLE cycle.
  - The other requester's rvalid_o stays 0.
  - rdata_o holds its value until the next response for that requester.
- Latency: accept at cycle N, mem_req_o at N+1, gnt at N+1, rvalid at N+2, rvalid_o at N+3. The next grant can occur at N+3.
- mem_rvalid_i in IDLE (stray, or arriving after reset) is ignored.
- dm_rd_i and dm_wr_i both high is illegal: the store wins and an assertion fires.
- Requests arriving in REQ/WAIT get no grant. Requesters hold their request.
- Asynchronous reset mid-transaction returns to IDLE immediately and discards all pending state.

Test Plan:
- Single fetch: if_req_i = 1, if_addr_i = 0x100. Expect if_gnt_o at N, mem_req_o = 1 / mem_addr_o = 0x100 / mem_we_o = 0 at N+1. mem_gnt_i at N+1, mem_rvalid_i with 0x00500093 at N+2 → if_rvalid_o = 1, if_rdata_o = 0x00500093 at N+3.
- Store: dm_wr_i = 1, addr 0x2004, wdata 0xDEADBEEF, type HALF. Expect mem_we_o = 1, mem_type_o = HALF. A write ack on mem_rvalid_i → dm_rvalid_o pulse; if_rvalid_o stays 0.
- Priority: if_req_i and dm_rd_i high in the same IDLE cycle → dm_gnt_o = 1, if_gnt_o = 0, starve_q = 1.
- Starvation: if_req_i held, dm_rd_i held continuously, STARVE_LIMIT = 4. Expect 4 data grants, then if_gnt_o on the 5th arbitration, then starve_q = 0.
- Memory back-pressure: mem_gnt_i held low 3 cycles. Expect mem_req_o and all mem_* fields stable for all 3; gnt and rvalid in the same cycle → state returns to IDLE.
- Reset mid-op: rsn_i low in WAIT → all outputs 0 immediately. A later mem_rvalid_i produces no rvalid_o.

Source files
------------

// File: rtl/segre_mem_arbiter_if.sv
// Shared types plus the bundle of fetch, data and memory-port signals around the arbiter.
// master = the arbiter's view; slave = the requesters and memory it serves.
package segre_pkg;
  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memop_data_type_e;
endpackage

interface segre_mem_arbiter_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = segre_pkg::WORD_SIZE
);
  import segre_pkg::*;

  logic                 if_req_i;
  logic [ADDR_SIZE-1:0] if_addr_i;
  logic                 if_gnt_o;
  logic                 if_rvalid_o;
  logic [WORD_SIZE-1:0] if_rdata_o;

  logic                 dm_rd_i;
  logic                 dm_wr_i;
  logic [ADDR_SIZE-1:0] dm_addr_i;
  logic [WORD_SIZE-1:0] dm_wdata_i;
  memop_data_type_e     dm_type_i;
  logic                 dm_gnt_o;
  logic                 dm_rvalid_o;
  logic [WORD_SIZE-1:0] dm_rdata_o;

  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDR_SIZE-1:0] mem_addr_o;
  logic [WORD_SIZE-1:0] mem_wdata_o;
  memop_data_type_e     mem_type_o;
  logic                 mem_gnt_i;
  logic                 mem_rvalid_i;
  logic [WORD_SIZE-1:0] mem_rdata_i;

  modport master (
    input  if_req_i, if_addr_i,
    input  dm_rd_i, dm_wr_i, dm_addr_i, dm_wdata_i, dm_type_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_type_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    output dm_rd_i, dm_wr_i, dm_addr_i, dm_wdata_i, dm_type_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_type_o
  );
endinterface

// File: rtl/segre_mem_arbiter.sv
// Shares one memory port between instruction fetch and the data memop path.
// One outstanding transaction; data has priority, a starvation counter guarantees fetch progress.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int ADDR_SIZE    = 32,
  parameter int WORD_SIZE    = segre_pkg::WORD_SIZE,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  segre_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  state_e               state_q, state_d;
  owner_e               owner_q;
  logic [STARVE_W-1:0]  starve_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  memop_data_type_e     type_q;
  logic                 we_q;
  logic                 if_rvalid_q, dm_rvalid_q;
  logic [WORD_SIZE-1:0] if_rdata_q, dm_rdata_q;

  logic dm_req, if_starved, dm_win, if_win, resp;

  assign dm_req     = bus.dm_rd_i | bus.dm_wr_i;
  assign if_starved = bus.if_req_i && (STARVE_LIMIT != 0) && (starve_q == STARVE_MAX);
  // Grants are combinational, so they are masked while reset is asserted.
  assign dm_win     = rsn_i && (state_q == S_IDLE) && dm_req && !if_starved;
  assign if_win     = rsn_i && (state_q == S_IDLE) && bus.if_req_i && !dm_win;
  assign resp       = bus.mem_rvalid_i &&
                      (((state_q == S_REQ) && bus.mem_gnt_i) || (state_q == S_WAIT));

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (dm_win || if_win) state_d = S_REQ;
      S_REQ:   if (bus.mem_gnt_i) state_d = bus.mem_rvalid_i ? S_IDLE : S_WAIT;
      S_WAIT:  if (bus.mem_rvalid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= WORD;
      we_q    <= 1'b0;
    end else if (dm_win) begin
      owner_q <= OWN_DM;
      addr_q  <= bus.dm_addr_i;
      wdata_q <= bus.dm_wdata_i;
      type_q  <= bus.dm_type_i;
      we_q    <= bus.dm_wr_i;
    end else if (if_win) begin
      owner_q <= OWN_IF;
      addr_q  <= bus.if_addr_i;
      type_q  <= WORD;
      we_q    <= 1'b0;
    end
  end

  // Counts arbitration losses of a pending fetch; only IDLE cycles arbitrate.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      starve_q <= '0;
    end else if (if_win) begin
      starve_q <= '0;
    end else if (dm_win && bus.if_req_i && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= resp && (owner_q == OWN_IF);
      dm_rvalid_q <= resp && (owner_q == OWN_DM);
      if (resp && (owner_q == OWN_IF)) if_rdata_q <= bus.mem_rdata_i;
      if (resp && (owner_q == OWN_DM)) dm_rdata_q <= bus.mem_rdata_i;
    end
  end

  assign bus.if_gnt_o    = if_win;
  assign bus.dm_gnt_o    = dm_win;
  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.dm_rvalid_o = dm_rvalid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.mem_req_o   = (state_q == S_REQ);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_type_o  = type_q;

  no_rd_and_wr: assert property (@(posedge clk_i) disable iff (!rsn_i)
    !(bus.dm_rd_i && bus.dm_wr_i));

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Self-checking bench for segre_mem_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of the arbitration and response rules.
module tb_segre_mem_arbiter;
  import segre_pkg::*;

  localparam int LIMIT = 4;

  logic clk;
  logic rsn;
  int   n_checks;
  int   n_fail;

  segre_mem_arbiter_if bus ();

  segre_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [135:0] all_outs = {bus.if_gnt_o, bus.if_rvalid_o, bus.if_rdata_o,
                           bus.dm_gnt_o, bus.dm_rvalid_o, bus.dm_rdata_o,
                           bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o,
                           bus.mem_wdata_o, bus.mem_type_o};
  wire [135:0] reset_outs = {134'd0, WORD};

  task automatic clear_inputs();
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.dm_rd_i      = 1'b0;
    bus.dm_wr_i      = 1'b0;
    bus.dm_addr_i    = '0;
    bus.dm_wdata_i   = '0;
    bus.dm_type_i    = WORD;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  // Stimulus only: called at the grant cycle's negedge; memory grants and answers in one cycle.
  // Returns at the negedge of the following IDLE cycle, where rvalid_o is high.
  task automatic mem_complete(input bit drop_if, input bit drop_dm, input logic [31:0] rd);
    @(negedge clk);
    if (drop_if) bus.if_req_i = 1'b0;
    if (drop_dm) begin
      bus.dm_rd_i = 1'b0;
      bus.dm_wr_i = 1'b0;
    end
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = rd;
    @(negedge clk);
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.if_req_i     = 1'b1;
    bus.dm_rd_i      = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    #12;
    n_checks++;
    if (all_outs !== reset_outs) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", all_outs, reset_outs);
    end
    @(negedge clk);
    clear_inputs();
    rsn = 1'b1;
    #1;
    n_checks++;
    if (all_outs !== reset_outs) begin
      n_fail++;
      $display("FAIL after_reset_idle: got %h expected %h", all_outs, reset_outs);
    end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h100;
    #1;
    n_checks++;
    if ({bus.if_gnt_o, bus.dm_gnt_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_gnt: got %b expected 10", {bus.if_gnt_o, bus.dm_gnt_o});
    end
    @(negedge clk);
    bus.if_req_i  = 1'b0;
    bus.mem_gnt_i = 1'b1;
    #1;
    n_checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_type_o} !== {2'b10, 32'h100, WORD}) begin
      n_fail++;
      $display("FAIL fetch_mem_fields: got req=%b we=%b addr=%h type=%0d expected req=1 we=0 addr=100 type=2",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_type_o);
    end
    @(negedge clk);
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0050_0093;
    #1;
    n_checks++;
    if ({bus.mem_req_o, bus.if_rvalid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_wait: got req=%b rvalid=%b expected 0 0", bus.mem_req_o, bus.if_rvalid_o);
    end
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if ({bus.if_rvalid_o, bus.dm_rvalid_o, bus.if_rdata_o} !== {2'b10, 32'h0050_0093}) begin
      n_fail++;
      $display("FAIL fetch_response: got if_rv=%b dm_rv=%b rdata=%h expected 1 0 00500093",
               bus.if_rvalid_o, bus.dm_rvalid_o, bus.if_rdata_o);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.if_rvalid_o, bus.if_rdata_o} !== {1'b0, 32'h0050_0093}) begin
      n_fail++;
      $display("FAIL fetch_pulse_hold: got rv=%b rdata=%h expected 0 00500093",
               bus.if_rvalid_o, bus.if_rdata_o);
    end
  endtask

  task automatic test_store();
    bus.dm_wr_i    = 1'b1;
    bus.dm_addr_i  = 32'h2004;
    bus.dm_wdata_i = 32'hDEAD_BEEF;
    bus.dm_type_i  = HALF;
    #1;
    n_checks++;
    if ({bus.if_gnt_o, bus.dm_gnt_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL store_gnt: got %b expected 01", {bus.if_gnt_o, bus.dm_gnt_o});
    end
    @(negedge clk);
    bus.dm_wr_i    = 1'b0;
    bus.dm_addr_i  = 32'h9999;
    bus.dm_wdata_i = 32'h0;
    bus.dm_type_i  = BYTE;
    bus.mem_gnt_i  = 1'b1;
    #1;
    n_checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_type_o} !==
        {2'b11, 32'h2004, 32'hDEAD_BEEF, HALF}) begin
      n_fail++;
      $display("FAIL store_mem_fields: got req=%b we=%b addr=%h wdata=%h type=%0d expected 1 1 2004 deadbeef 1",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_type_o);
    end
    @(negedge clk);
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h1234_5678;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if ({bus.dm_rvalid_o, bus.if_rvalid_o, bus.if_rdata_o} !== {2'b10, 32'h0050_0093}) begin
      n_fail++;
      $display("FAIL store_ack: got dm_rv=%b if_rv=%b if_rdata=%h expected 1 0 00500093",
               bus.dm_rvalid_o, bus.if_rvalid_o, bus.if_rdata_o);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h200;
    bus.dm_rd_i   = 1'b1;
    bus.dm_addr_i = 32'h3000;
    bus.dm_type_i = WORD;
    #1;
    n_checks++;
    if ({bus.if_gnt_o, bus.dm_gnt_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL priority_gnt: got %b expected 01", {bus.if_gnt_o, bus.dm_gnt_o});
    end
    mem_complete(1'b0, 1'b1, 32'hAAAA_0001);
    #1;
    n_checks++;
    if ({bus.if_gnt_o, bus.dm_rvalid_o, bus.dm_rdata_o} !== {2'b11, 32'hAAAA_0001}) begin
      n_fail++;
      $display("FAIL priority_then_fetch: got if_gnt=%b dm_rv=%b dm_rdata=%h expected 1 1 aaaa0001",
               bus.if_gnt_o, bus.dm_rvalid_o, bus.dm_rdata_o);
    end
    mem_complete(1'b1, 1'b0, 32'h0000_0013);
  endtask

  task automatic test_starvation();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h400;
    bus.dm_rd_i   = 1'b1;
    for (int round = 0; round < 2; round++) begin
      bus.if_req_i = 1'b1;
      for (int k = 0; k <= LIMIT; k++) begin
        bus.dm_addr_i = $urandom;
        #1;
        n_checks++;
        if ({bus.if_gnt_o, bus.dm_gnt_o} !== ((k == LIMIT) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL starve_r%0d_k%0d: got %b expected %b", round, k,
                   {bus.if_gnt_o, bus.dm_gnt_o}, (k == LIMIT) ? 2'b10 : 2'b01);
        end
        mem_complete(k == LIMIT, 1'b0, $urandom);
      end
    end
    bus.dm_rd_i = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.dm_rd_i    = 1'b1;
    bus.dm_addr_i  = 32'h5008;
    bus.dm_wdata_i = 32'h1111_2222;
    bus.dm_type_i  = BYTE;
    #1;
    n_checks++;
    if (bus.dm_gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_gnt: got %b expected 1", bus.dm_gnt_o);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.dm_rd_i    = 1'b0;
      bus.dm_addr_i  = $urandom;
      bus.dm_wdata_i = $urandom;
      bus.dm_type_i  = HALF;
      bus.mem_gnt_i    = (c == 3);
      bus.mem_rvalid_i = (c == 3);
      bus.mem_rdata_i  = 32'hCAFE_F00D;
      #1;
      n_checks++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_type_o} !==
          {2'b10, 32'h5008, 32'h1111_2222, BYTE}) begin
        n_fail++;
        $display("FAIL bp_stable_c%0d: got req=%b we=%b addr=%h wdata=%h type=%0d", c,
                 bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_type_o);
      end
    end
    @(negedge clk);
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.if_req_i     = 1'b1;
    bus.if_addr_i    = 32'h500;
    #1;
    n_checks++;
    if ({bus.mem_req_o, bus.dm_rvalid_o, bus.dm_rdata_o, bus.if_gnt_o} !== {2'b01, 32'hCAFE_F00D, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_same_cycle_idle: got req=%b dm_rv=%b dm_rdata=%h if_gnt=%b expected 0 1 cafef00d 1",
               bus.mem_req_o, bus.dm_rvalid_o, bus.dm_rdata_o, bus.if_gnt_o);
    end
    mem_complete(1'b1, 1'b0, 32'h0000_0033);
  endtask

  task automatic test_reset_mid_op();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h600;
    @(negedge clk);
    bus.if_req_i  = 1'b0;
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    #2;
    rsn = 1'b0;
    #1;
    n_checks++;
    if (all_outs !== reset_outs) begin
      n_fail++;
      $display("FAIL reset_mid_op: got %h expected %h", all_outs, reset_outs);
    end
    @(negedge clk);
    rsn = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hBADB_AD00;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if ({bus.if_rvalid_o, bus.dm_rvalid_o, bus.if_rdata_o, bus.mem_req_o} !== 35'd0) begin
      n_fail++;
      $display("FAIL stray_rvalid: got if_rv=%b dm_rv=%b if_rdata=%h req=%b expected all 0",
               bus.if_rvalid_o, bus.dm_rvalid_o, bus.if_rdata_o, bus.mem_req_o);
    end
  endtask

  // Transaction-level model: one outstanding access, data first unless fetch has lost LIMIT times.
  task automatic test_random();
    bit               if_pend = 0, dm_pend = 0, dm_is_wr = 0;
    logic [31:0]      if_a = '0, dm_a = '0, dm_wd = '0;
    memop_data_type_e dm_t = WORD;
    bit               busy = 0, mem_acc = 0, resp_due = 0, resp_dm = 0;
    bit               t_dm = 0, t_we = 0;
    logic [31:0]      t_addr = '0, t_wdata = '0;
    memop_data_type_e t_type = WORD;
    logic [31:0]      exp_if_rd = '0, exp_dm_rd = '0;
    int               starve = 0;
    bit               mg, mr, exp_if, exp_dm, starved;

    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1;
        if_a    = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_pend && $urandom_range(0, 1) == 0) begin
        dm_pend  = 1;
        dm_is_wr = 1'($urandom_range(0, 1));
        dm_a     = $urandom;
        dm_wd    = $urandom;
        dm_t     = memop_data_type_e'($urandom_range(0, 2));
      end
      bus.if_req_i   = if_pend;
      bus.if_addr_i  = if_a;
      bus.dm_rd_i    = dm_pend && !dm_is_wr;
      bus.dm_wr_i    = dm_pend && dm_is_wr;
      bus.dm_addr_i  = dm_a;
      bus.dm_wdata_i = dm_wd;
      bus.dm_type_i  = dm_t;
      mg = 0;
      mr = 0;
      if (busy && !mem_acc) begin
        mg = ($urandom_range(0, 2) != 0);
        mr = mg && ($urandom_range(0, 1) == 1);
      end else if (busy) begin
        mr = ($urandom_range(0, 1) == 1);
      end else begin
        mr = ($urandom_range(0, 4) == 0);
      end
      bus.mem_gnt_i    = mg;
      bus.mem_rvalid_i = mr;
      bus.mem_rdata_i  = $urandom;
      #1;

      n_checks++;
      if ({bus.if_rvalid_o, bus.dm_rvalid_o} !== {resp_due && !resp_dm, resp_due && resp_dm}) begin
        n_fail++;
        $display("FAIL rnd_rvalid c%0d: got %b expected %b", cyc,
                 {bus.if_rvalid_o, bus.dm_rvalid_o}, {resp_due && !resp_dm, resp_due && resp_dm});
      end
      n_checks++;
      if ({bus.if_rdata_o, bus.dm_rdata_o} !== {exp_if_rd, exp_dm_rd}) begin
        n_fail++;
        $display("FAIL rnd_rdata c%0d: got %h %h expected %h %h", cyc,
                 bus.if_rdata_o, bus.dm_rdata_o, exp_if_rd, exp_dm_rd);
      end

      exp_if = 0;
      exp_dm = 0;
      if (!busy) begin
        starved = if_pend && (starve == LIMIT);
        exp_dm  = dm_pend && !starved;
        exp_if  = if_pend && !exp_dm;
      end
      n_checks++;
      if ({bus.if_gnt_o, bus.dm_gnt_o} !== {exp_if, exp_dm}) begin
        n_fail++;
        $display("FAIL rnd_gnt c%0d: got %b expected %b (starve=%0d)", cyc,
                 {bus.if_gnt_o, bus.dm_gnt_o}, {exp_if, exp_dm}, starve);
      end

      n_checks++;
      if (busy && !mem_acc) begin
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_type_o} !== {1'b1, t_we, t_addr, t_type} ||
            (t_we && bus.mem_wdata_o !== t_wdata)) begin
          n_fail++;
          $display("FAIL rnd_mem c%0d: got req=%b we=%b addr=%h wdata=%h type=%0d expected 1 %b %h %h %0d",
                   cyc, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_type_o,
                   t_we, t_addr, t_wdata, t_type);
        end
      end else if (bus.mem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_mem_idle c%0d: got req=%b expected 0", cyc, bus.mem_req_o);
      end

      resp_due = 0;
      if (!busy) begin
        if (exp_dm) begin
          t_dm = 1; t_we = dm_is_wr; t_addr = dm_a; t_wdata = dm_wd; t_type = dm_t;
          busy = 1; mem_acc = 0; dm_pend = 0;
          if (if_pend && starve < LIMIT) starve++;
        end else if (exp_if) begin
          t_dm = 0; t_we = 0; t_addr = if_a; t_type = WORD;
          busy = 1; mem_acc = 0; if_pend = 0; starve = 0;
        end
      end else if (!mem_acc) begin
        if (mg && mr) begin
          busy = 0; resp_due = 1;
        end else if (mg) begin
          mem_acc = 1;
        end
      end else if (mr) begin
        busy = 0; resp_due = 1;
      end
      if (resp_due) begin
        resp_dm = t_dm;
        if (t_dm) exp_dm_rd = bus.mem_rdata_i;
        else      exp_if_rd = bus.mem_rdata_i;
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rsn      = 1'b0;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_store();
    test_priority();
    test_starvation();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
